// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the column-serial round stages.
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] state_t;

   localparam byte_t GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } cm_state_e;

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

   // Column 0 occupies the most significant word of the state.
   function automatic logic [6:0] col_lsb(input logic [1:0] c);
      return 7'(7'd96 - {c, 5'b0});
   endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational single-column MixColumns with pass-through bypass.
module aes_mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col_i,
   input  logic        bypass_i,
   output logic [31:0] col_o
);

   byte_t a0, a1, a2, a3;
   byte_t x0, x1, x2, x3;

   always_comb begin
      a0 = col_i[31:24];
      a1 = col_i[23:16];
      a2 = col_i[15:8];
      a3 = col_i[7:0];
      x0 = xtime(a0);
      x1 = xtime(a1);
      x2 = xtime(a2);
      x3 = xtime(a3);
      if (bypass_i) begin
         col_o = col_i;
      end else begin
         col_o = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                  a0 ^ x1 ^ x2 ^ a2 ^ a3,
                  a0 ^ a1 ^ x2 ^ x3 ^ a3,
                  x0 ^ a0 ^ a1 ^ a2 ^ x3};
      end
   end

endmodule

// File: rtl/col_mix_accum.sv
// Column-serial MixColumns + AddRoundKey: walks columns 0..3, accumulating the next round state.
module col_mix_accum
   import aes_pkg::*;
#(
   parameter int unsigned PIPE = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         mc_bypass,
   input  logic [7:0]   in_1,
   input  logic [7:0]   in_2,
   input  logic [7:0]   in_3,
   input  logic [7:0]   in_4,
   input  logic [31:0]  key_word,
   output logic [2:0]   col_idx,
   output logic         busy,
   output logic         done,
   output logic [127:0] state_out
);

   cm_state_e   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        byp_q, byp_d;
   state_t      st_q, st_d;
   logic        pv_q, pv_d;
   logic [1:0]  pidx_q, pidx_d;
   word_t       pword_q, pword_d;

   word_t       mc_out;
   word_t       res;
   logic        wr_en;
   logic [1:0]  wr_idx;
   word_t       wr_word;

   aes_mix_column u_mix (
      .col_i    ({in_1, in_2, in_3, in_4}),
      .bypass_i (byp_q),
      .col_o    (mc_out)
   );

   assign res = mc_out ^ key_word;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byp_d   = byp_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            cnt_d = '0;
            if (start) begin
               state_d = ST_RUN;
               byp_d   = mc_bypass;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_q == 2'd3) begin
               // With the pipe stage the index holds at 3 through the flush cycle.
               state_d = (PIPE != 0) ? ST_FLUSH : ST_DONE;
               cnt_d   = (PIPE != 0) ? cnt_q : '0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_FLUSH: begin
            state_d = ST_DONE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pv_d    = (PIPE != 0) && (state_q == ST_RUN);
      pidx_d  = cnt_q;
      pword_d = res;
      if (PIPE != 0) begin
         wr_en   = pv_q;
         wr_idx  = pidx_q;
         wr_word = pword_q;
      end else begin
         wr_en   = (state_q == ST_RUN);
         wr_idx  = cnt_q;
         wr_word = res;
      end
      st_d = st_q;
      if (wr_en) begin
         st_d[col_lsb(wr_idx) +: 32] = wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         byp_q   <= 1'b0;
         st_q    <= '0;
         pv_q    <= 1'b0;
         pidx_q  <= '0;
         pword_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byp_q   <= byp_d;
         st_q    <= st_d;
         pv_q    <= pv_d;
         pidx_q  <= pidx_d;
         pword_q <= pword_d;
      end
   end

   assign col_idx   = {1'b0, cnt_q};
   assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign done      = (state_q == ST_DONE);
   assign state_out = st_q;

endmodule

// File: tb/tb_col_mix_accum.sv
// Directed bench for col_mix_accum, exercising PIPE=0 and PIPE=1 instances side by side.
module tb_col_mix_accum;

   typedef struct {
      string        name;
      logic [127:0] cols;
      logic [127:0] keys;
      logic         byp;
      logic         tog;
      logic         spulse;
      logic [127:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         mc_bypass;
   logic         start0, start1;
   logic [127:0] cur_c0, cur_k0, cur_c1, cur_k1;
   logic [31:0]  col0_w, col1_w, key0_w, key1_w;
   logic [2:0]   col_idx0, col_idx1;
   logic         busy0, busy1, done0, done1;
   logic [127:0] so0, so1;

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] FIPS_C = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_K = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_E = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] MC_C   = 128'hdb135345f20a225cc6c6c6c601010101;
   localparam logic [127:0] MC_E   = 128'h8e4da1bc9fdc589dc6c6c6c601010101;

   function automatic logic [31:0] colw(input logic [127:0] s, input logic [2:0] c);
      logic [127:0] t;
      t = s << (32 * c[1:0]);
      return t[127:96];
   endfunction

   always_comb begin
      col0_w = colw(cur_c0, col_idx0);
      key0_w = colw(cur_k0, col_idx0);
      col1_w = colw(cur_c1, col_idx1);
      key1_w = colw(cur_k1, col_idx1);
   end

   col_mix_accum #(.PIPE(0)) u_p0 (
      .clk(clk), .reset(reset), .start(start0), .mc_bypass(mc_bypass),
      .in_1(col0_w[31:24]), .in_2(col0_w[23:16]), .in_3(col0_w[15:8]), .in_4(col0_w[7:0]),
      .key_word(key0_w), .col_idx(col_idx0), .busy(busy0), .done(done0), .state_out(so0)
   );

   col_mix_accum #(.PIPE(1)) u_p1 (
      .clk(clk), .reset(reset), .start(start1), .mc_bypass(mc_bypass),
      .in_1(col1_w[31:24]), .in_2(col1_w[23:16]), .in_3(col1_w[15:8]), .in_4(col1_w[7:0]),
      .key_word(key1_w), .col_idx(col_idx1), .busy(busy1), .done(done1), .state_out(so1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input string n, input logic [127:0] c, input logic [127:0] k,
                                input logic b, input logic t, input logic s, input logic [127:0] e);
      vec_t v;
      v.name = n; v.cols = c; v.keys = k; v.byp = b; v.tog = t; v.spulse = s; v.exp = e;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int d0first = 0, d1first = 0, d0n = 0, d1n = 0, b0n = 0, b1n = 0;
      logic [127:0] so0_at = '0, so1_at = '0;
      logic [2:0] ci0 [1:6];
      logic [2:0] ci1 [1:6];
      logic bit2 = 1'b0;
      @(negedge clk);
      cur_c0 = v.cols; cur_k0 = v.keys; cur_c1 = v.cols; cur_k1 = v.keys;
      mc_bypass = v.byp; start0 = 1'b1; start1 = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (done0) begin d0n++; if (d0first == 0) begin d0first = cyc; so0_at = so0; end end
         if (done1) begin d1n++; if (d1first == 0) begin d1first = cyc; so1_at = so1; end end
         if (busy0) b0n++;
         if (busy1) b1n++;
         if (cyc <= 6) begin ci0[cyc] = col_idx0; ci1[cyc] = col_idx1; end
         if (col_idx0[2] || col_idx1[2]) bit2 = 1'b1;
         if (cyc == 1) begin
            start0 = 1'b0; start1 = 1'b0;
            if (v.tog) mc_bypass = ~v.byp;
         end
         if (v.spulse && cyc == 2) begin start0 = 1'b1; start1 = 1'b1; end
         if (v.spulse && cyc == 3) begin start0 = 1'b0; start1 = 1'b0; end
      end
      chk($sformatf("%s p0 result", v.name), so0_at, v.exp);
      chk($sformatf("%s p1 result", v.name), so1_at, v.exp);
      chk($sformatf("%s p0 hold", v.name), so0, v.exp);
      chk($sformatf("%s p0 done cycle", v.name), 128'(d0first), 128'd5);
      chk($sformatf("%s p1 done cycle", v.name), 128'(d1first), 128'd6);
      chk($sformatf("%s p0 done count", v.name), 128'(d0n), 128'd1);
      chk($sformatf("%s p1 done count", v.name), 128'(d1n), 128'd1);
      chk($sformatf("%s p0 busy width", v.name), 128'(b0n), 128'd4);
      chk($sformatf("%s p1 busy width", v.name), 128'(b1n), 128'd5);
      chk($sformatf("%s p0 col_idx seq", v.name),
          128'({ci0[1], ci0[2], ci0[3], ci0[4], ci0[5]}), 128'({3'd0, 3'd1, 3'd2, 3'd3, 3'd0}));
      chk($sformatf("%s p1 col_idx seq", v.name),
          128'({ci1[1], ci1[2], ci1[3], ci1[4], ci1[5], ci1[6]}),
          128'({3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0}));
      chk($sformatf("%s col_idx bit2", v.name), 128'(bit2), 128'd0);
   endtask

   task automatic run_restart();
      int n0 = 0, n1 = 0, c0a = 0, c0b = 0, c1a = 0, c1b = 0;
      logic rs0 = 1'b0, rs1 = 1'b0;
      @(negedge clk);
      cur_c0 = FIPS_C; cur_k0 = FIPS_K; cur_c1 = FIPS_C; cur_k1 = FIPS_K;
      mc_bypass = 1'b0; start0 = 1'b1; start1 = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin start0 = 1'b0; start1 = 1'b0; end
         if (rs0) begin start0 = 1'b0; rs0 = 1'b0; end
         if (rs1) begin start1 = 1'b0; rs1 = 1'b0; end
         if (done0) begin
            n0++;
            if (n0 == 1) begin
               c0a = cyc;
               chk("restart p0 first result", so0, FIPS_E);
               cur_c0 = MC_C; cur_k0 = '0; start0 = 1'b1; rs0 = 1'b1;
            end else c0b = cyc;
         end
         if (done1) begin
            n1++;
            if (n1 == 1) begin
               c1a = cyc;
               chk("restart p1 first result", so1, FIPS_E);
               cur_c1 = MC_C; cur_k1 = '0; start1 = 1'b1; rs1 = 1'b1;
            end else c1b = cyc;
         end
      end
      chk("restart p0 done count", 128'(n0), 128'd2);
      chk("restart p1 done count", 128'(n1), 128'd2);
      chk("restart p0 done cycles", 128'({c0a[7:0], c0b[7:0]}), 128'({8'd5, 8'd10}));
      chk("restart p1 done cycles", 128'({c1a[7:0], c1b[7:0]}), 128'({8'd6, 8'd12}));
      chk("restart p0 second result", so0, MC_E);
      chk("restart p1 second result", so1, MC_E);
   endtask

   task automatic run_reset_abort();
      int late = 0;
      @(negedge clk);
      cur_c0 = FIPS_C; cur_k0 = FIPS_K; cur_c1 = FIPS_C; cur_k1 = FIPS_K;
      mc_bypass = 1'b0; start0 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset p0 state_out", so0, '0);
      chk("reset p1 state_out", so1, '0);
      chk("reset ctl outputs", 128'({col_idx0, busy0, done0, col_idx1, busy1, done1}), '0);
      reset = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (done0 || done1 || busy0 || busy1) late++;
      end
      chk("reset no done afterwards", 128'(late), '0);
      chk("reset p0 state_out held", so0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [5];
      vt[0] = mkv("mc_cols",      MC_C,   '0,     1'b0, 1'b0, 1'b0, MC_E);
      vt[1] = mkv("fips_r1",      FIPS_C, FIPS_K, 1'b0, 1'b0, 1'b0, FIPS_E);
      vt[2] = mkv("bypass_not",   FIPS_C, '1,     1'b1, 1'b0, 1'b0,
                  128'h2b40a2cf1f4bad5147beee0ee1d8671a);
      vt[3] = mkv("bypass_tog",   FIPS_C, FIPS_K, 1'b0, 1'b1, 1'b0, FIPS_E);
      vt[4] = mkv("start_in_run", FIPS_C, FIPS_K, 1'b1, 1'b1, 1'b1, FIPS_C ^ FIPS_K);

      reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mc_bypass = 1'b0;
      cur_c0 = '0; cur_k0 = '0; cur_c1 = '0; cur_k1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("init p0 state_out", so0, '0);
      chk("init p1 state_out", so1, '0);
      chk("init ctl outputs", 128'({col_idx0, busy0, done0, col_idx1, busy1, done1}), '0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vt[i]);
      run_restart();
      repeat (3) @(negedge clk);
      run_reset_abort();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
